imem_fetch_ctrl: RTL and testbench

Sequencing controller for the 64-word, 32-bit instruction memory, which has a 1-cycle synchronous read. It loads a program into the memory from a word-serial loader port, then runs the fetch sequence that feeds the core. The fetch sequence handles PC increment, stall replay and branch redirect. It sits between the loader/core front end and the memory's read and write ports.

---
 rtl/imem_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencing controller.
// Loads a program word-serially into the 64-word instruction memory, then
// drives the fetch stream for the core. Memory reads are 1-cycle synchronous,
// so the word shown in a cycle belongs to the address issued the cycle before.
// The fetch stream handles sequential PC increment, stall replay and branch
// redirect.
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;        // next sequential fetch address
    logic [ADDR_W-1:0] rd_pc_r;     // address of the read currently in flight
    logic              pend_r;      // a read is in flight, its word shows this cycle
    logic [ADDR_W-1:0] ld_cnt_r;    // next load write address
    logic              load_done_r;

    logic [ADDR_W-1:0] mem_raddr_s;
    logic              mem_we_s;

    // Word-address increment; wraps modulo the memory depth.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_ONE;
    endfunction

    // Mode FSM plus the fetch/load address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_ADDR;
            rd_pc_r     <= ADDR_ZERO;
            pend_r      <= 1'b0;
            ld_cnt_r    <= ADDR_ZERO;
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // load_en outranks start
                    if (load_en) begin
                        state_r  <= ST_LOAD;
                        ld_cnt_r <= ADDR_ZERO;
                    end else if (start) begin
                        state_r <= ST_RUN;
                        pc_r    <= RESET_ADDR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Dropping load_en ends the load without writing this cycle.
                    if (!load_en) begin
                        state_r     <= ST_IDLE;
                        load_done_r <= 1'b1;
                    end else if (load_valid) begin
                        if (ld_cnt_r == LAST_ADDR) begin
                            state_r     <= ST_IDLE;
                            load_done_r <= 1'b1;
                        end else begin
                            ld_cnt_r <= addr_inc(ld_cnt_r);
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_r <= ST_IDLE;
                        pend_r  <= 1'b0;
                    end else if (redirect) begin
                        rd_pc_r <= redirect_pc;
                        pc_r    <= addr_inc(redirect_pc);
                        pend_r  <= 1'b1;
                    end else if (stall && pend_r) begin
                        // Replay: re-read the same address, keep everything.
                        rd_pc_r <= rd_pc_r;
                        pc_r    <= pc_r;
                    end else begin
                        rd_pc_r <= pc_r;
                        pc_r    <= addr_inc(pc_r);
                        pend_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pend_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read-address select: redirect target, replay address or sequential PC.
    always_comb begin
        mem_raddr_s = pc_r;
        case (state_r)
            ST_RUN: begin
                if (halt) begin
                    mem_raddr_s = pc_r;
                end else if (redirect) begin
                    mem_raddr_s = redirect_pc;
                end else if (stall && pend_r) begin
                    mem_raddr_s = rd_pc_r;
                end else begin
                    mem_raddr_s = pc_r;
                end
            end
            default: mem_raddr_s = pc_r;
        endcase
    end

    // Write strobe: only in LOAD while load_en is still held.
    always_comb begin
        mem_we_s = 1'b0;
        if ((state_r == ST_LOAD) && load_en && load_valid) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    assign load_ready = (state_r == ST_LOAD);
    assign load_done  = load_done_r;
    assign inst_valid = pend_r;
    assign inst       = mem_rdata;
    assign inst_pc    = rd_pc_r;
    assign mem_we     = mem_we_s;
    assign mem_waddr  = ld_cnt_r;
    assign mem_wdata  = load_data;
    assign mem_raddr  = mem_raddr_s;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: bench-side synchronous memory, directed
// load/fetch sequences, a table of fetch vectors and randomized traffic, all
// checked against a stream-level reference model.
module tb_imem_fetch_ctrl;

    localparam logic [5:0] RST_PC = 6'd0;

    logic        clk = 1'b0;
    logic        rst_n, load_en, load_valid, start, halt, stall, redirect;
    logic [31:0] load_data, inst, mem_wdata, mem_rdata;
    logic [5:0]  redirect_pc, inst_pc, mem_waddr, mem_raddr;
    logic        load_ready, load_done, inst_valid, mem_we;

    int total = 0;
    int bad   = 0;

    // bench memory and the model's view of memory contents
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    // reference model: mode 0=idle 1=load 2=run
    int         m_mode;
    logic       m_valid, m_done;
    logic [5:0] m_shown, m_seq, m_ptr, m_raddr;

    // memory-port values captured before the edge
    logic        cap_we;
    logic [5:0]  cap_waddr, cap_raddr;
    logic [31:0] cap_wdata;

    typedef struct {
        logic       st, hl, sl, rd;
        logic [5:0] rpc;
        logic       ev;
        logic [5:0] epc;
    } vec_t;
    vec_t tbl [17];

    imem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_done(load_done),
        .start(start), .halt(halt), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_seq   = RST_PC;
        m_ptr   = 6'd0;
        m_shown = 6'd0;
    endtask

    // Stream-level view: the word shown next cycle is whatever address is read now.
    task automatic model_advance(input logic le, lv, input logic [31:0] ld,
                                 input logic st, hl);
        logic done_n;
        done_n = 1'b0;
        case (m_mode)
            0: begin
                if (le) begin
                    m_mode = 1;
                    m_ptr  = 6'd0;
                end else if (st) begin
                    m_mode = 2;
                    m_seq  = RST_PC;
                end
            end
            1: begin
                if (!le) begin
                    m_mode = 0;
                    done_n = 1'b1;
                end else if (lv) begin
                    ref_mem[m_ptr] = ld;
                    if (m_ptr == 6'd63) begin
                        m_mode = 0;
                        done_n = 1'b1;
                    end else begin
                        m_ptr = m_ptr + 6'd1;
                    end
                end
            end
            default: begin
                if (hl) begin
                    m_mode  = 0;
                    m_valid = 1'b0;
                end else begin
                    m_shown = m_raddr;
                    m_seq   = 6'((int'(m_raddr) + 1) % 64);
                    m_valid = 1'b1;
                end
            end
        endcase
        m_done = done_n;
    endtask

    // One clock cycle: memory update at the rising edge, drive at the falling
    // edge, check 1 time unit later. Returns with outputs still sampleable.
    task automatic step(input logic rn, le, lv, input logic [31:0] ld,
                        input logic st, hl, sl, rd, input logic [5:0] rpc);
        logic e_we;
        @(posedge clk);
        mem_rdata = mem[cap_raddr];
        if (cap_we) mem[cap_waddr] = cap_wdata;
        @(negedge clk);
        rst_n = rn; load_en = le; load_valid = lv; load_data = ld;
        start = st; halt = hl; stall = sl; redirect = rd; redirect_pc = rpc;
        #1;
        if (!rn) model_reset();
        m_raddr = m_seq;
        if (m_mode == 2 && !hl) begin
            if (rd) m_raddr = rpc;
            else if (sl && m_valid) m_raddr = m_shown;
        end
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        if (m_valid) begin
            chk("inst_pc", 32'(inst_pc), 32'(m_shown));
            chk("inst", inst, ref_mem[m_shown]);
        end
        chk("load_ready", 32'(load_ready), 32'(m_mode == 1));
        e_we = (m_mode == 1) && le && lv;
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(m_ptr));
            chk("mem_wdata", mem_wdata, ld);
        end
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("mem_raddr", 32'(mem_raddr), 32'(m_raddr));
        cap_we = mem_we; cap_waddr = mem_waddr; cap_wdata = mem_wdata; cap_raddr = mem_raddr;
        if (rn) model_advance(le, lv, ld, st, hl);
    endtask

    task automatic nop();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic go();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    endtask

    task automatic stop();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    endtask

    initial begin
        logic le_hold;
        rst_n = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = 32'h0;
        start = 1'b0; halt = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 6'd0;
        mem_rdata = 32'h0;
        cap_we = 1'b0; cap_waddr = 6'd0; cap_wdata = 32'h0; cap_raddr = 6'd0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h5000_0000 + 32'(i);
            ref_mem[i] = 32'h5000_0000 + 32'(i);
        end
        model_reset();

        // fetch table: start, stream, 3-cycle stall at pc 5, redirect+stall, halt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd4};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd5};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd5};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 6'd5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd5};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd6};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd40, 1'b1, 6'd7};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd40};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 6'd41};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd42};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0};

        // reset state
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_raddr", 32'(mem_raddr), 32'(RST_PC));
        nop();

        // short load: 3 words then load_en drops (load_valid still high)
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            chk("ld3_we", 32'(mem_we), 32'd1);
            chk("ld3_waddr", 32'(mem_waddr), 32'(i));
        end
        step(1'b1, 1'b0, 1'b1, 32'hB000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("ld3_exit_no_write", 32'(mem_we), 32'd0);
        nop();
        chk("ld3_done", 32'(load_done), 32'd1);
        nop();
        chk("ld3_done_pulse", 32'(load_done), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        step(1'b1, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("reload_waddr", 32'(mem_waddr), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        nop();

        // full load of 64 words
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
            chk("ld64_we", 32'(mem_we), 32'd1);
            chk("ld64_waddr", 32'(mem_waddr), 32'(i));
        end
        nop();
        chk("ld64_done", 32'(load_done), 32'd1);
        chk("ld64_idle", 32'(load_ready), 32'd0);

        // table-driven fetch vectors
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, tbl[i].st, tbl[i].hl, tbl[i].sl, tbl[i].rd, tbl[i].rpc);
            chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_pc", 32'(inst_pc), 32'(tbl[i].epc));
                chk("tbl_inst", inst, 32'hA000_0000 + 32'(tbl[i].epc));
            end
        end

        // full sweep with wrap 63 -> 0
        go();
        nop();
        chk("sweep_first_invalid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 66; i++) begin
            nop();
            chk("sweep_valid", 32'(inst_valid), 32'd1);
            chk("sweep_pc", 32'(inst_pc), 32'(i % 64));
            chk("sweep_inst", inst, 32'hA000_0000 + 32'(i % 64));
        end
        stop();
        nop();
        chk("halt_invalid", 32'(inst_valid), 32'd0);

        // reset in the middle of RUN, then restart
        go(); nop(); nop(); nop();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
        chk("midrst_invalid", 32'(inst_valid), 32'd0);
        chk("midrst_raddr", 32'(mem_raddr), 32'(RST_PC));
        nop();
        go(); nop(); nop();
        chk("restart_valid", 32'(inst_valid), 32'd1);
        chk("restart_pc", 32'(inst_pc), 32'(RST_PC));
        stop();
        nop();

        // randomized traffic against the model
        le_hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 19) == 0) le_hold = ~le_hold;
            step(($urandom_range(0, 149) != 0), le_hold, ($urandom_range(0, 3) != 0),
                 $urandom, ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 6'($urandom_range(0, 63)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
